// File: rtl/dmem_pkg.sv
// dmem_pkg: shared size encodings, FSM states and lane-count helper for banked_data_memory
package dmem_pkg;
    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_RSV = 2'b11;

    typedef enum logic {ST_IDLE, ST_SPLIT} state_e;

    function automatic int lane_bits(input int lanes);
        return $clog2(lanes);
    endfunction
endpackage

// File: rtl/dmem_lane.sv
// dmem_lane: one 8-bit synchronous single-port lane RAM with registered read data
module dmem_lane #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          re,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    din,
    output logic [7:0]    dout
);
    logic [7:0] mem [2**AW];
    logic [7:0] dout_q;

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= din;
        if (re) dout_q <= mem[addr];
    end

    assign dout = dout_q;
endmodule

// File: rtl/banked_data_memory.sv
// banked_data_memory: byte-lane banked data memory with lane steering, load extension
// and two-beat handling of accesses that straddle a word boundary
module banked_data_memory
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int LANES      = 4,
    localparam int XLEN      = 8 * LANES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  resp_valid,
    output logic [XLEN-1:0]       resp_rdata,
    output logic                  resp_err
);
    localparam int LB = lane_bits(LANES);
    localparam int WW = ADDR_WIDTH - LB;

    function automatic logic [LB:0] nbytes(input logic [1:0] sz);
        return (sz == SZ_B) ? (LB+1)'(1) : (sz == SZ_H) ? (LB+1)'(2) : (LB+1)'(LANES);
    endfunction

    function automatic logic is_split(input logic [LB-1:0] o, input logic [LB:0] k);
        return int'(o) + int'(k) > LANES;
    endfunction

    // Beat 0 covers lanes o..o+k-1 within the word; beat 1 covers the overflow from lane 0.
    function automatic logic [LANES-1:0] beat_mask(input logic [LB-1:0] o, input logic [LB:0] k,
                                                   input logic second);
        logic [LANES-1:0] m;
        int e;
        e = int'(o) + int'(k);
        for (int i = 0; i < LANES; i++)
            m[i] = second ? (i + LANES < e) : (i >= int'(o) && i < e);
        return m;
    endfunction

    function automatic logic [XLEN-1:0] bytes_of(input logic [LANES-1:0] m);
        logic [XLEN-1:0] r;
        for (int i = 0; i < LANES; i++) r[8*i +: 8] = {8{m[i]}};
        return r;
    endfunction

    function automatic logic [XLEN-1:0] rotl(input logic [XLEN-1:0] w, input logic [LB-1:0] o);
        logic [2*XLEN-1:0] t;
        t = {w, w} << (8 * o);
        return t[2*XLEN-1:XLEN];
    endfunction

    function automatic logic [XLEN-1:0] rotr(input logic [XLEN-1:0] w, input logic [LB-1:0] o);
        logic [2*XLEN-1:0] t;
        t = {w, w} >> (8 * o);
        return t[XLEN-1:0];
    endfunction

    state_e                  state_q, state_d;
    logic                    req_ready_q, req_ready_d;
    logic                    resp_valid_q, resp_valid_d;
    logic                    resp_err_q, resp_err_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [1:0]              size_q, size_d;
    logic                    uns_q, uns_d;
    logic                    we_q, we_d;
    logic [XLEN-1:0]         wdata_q, wdata_d;
    logic [XLEN-1:0]         b0_q, b0_d;
    logic [XLEN-1:0]         hold_q, hold_d;

    logic                    accept, err, split_now, in_split;
    logic [LB-1:0]           off, q_off;
    logic [LB:0]             nb, q_n;
    logic [WW-1:0]           widx;
    logic [LANES-1:0]        en, lwe, lre, m1;
    logic [XLEN-1:0]         din, dout, gath, rot, msk, ext, rdata_now;
    logic                    sb;

    always_comb begin
        in_split     = state_q == ST_SPLIT;
        accept       = !in_split && req_valid;
        off          = req_addr[LB-1:0];
        nb           = nbytes(req_size);
        err          = req_size == SZ_RSV;
        split_now    = is_split(off, nb);
        q_off        = addr_q[LB-1:0];
        q_n          = nbytes(size_q);
        widx         = in_split ? addr_q[ADDR_WIDTH-1:LB] + WW'(1) : req_addr[ADDR_WIDTH-1:LB];
        en           = in_split ? beat_mask(q_off, q_n, 1'b1)
                                : (accept && !err) ? beat_mask(off, nb, 1'b0) : '0;
        lwe          = en & {LANES{in_split ? we_q : req_we}};
        lre          = en & ~lwe;
        din          = in_split ? rotl(wdata_q, q_off) : rotl(req_wdata, off);
        state_d      = (accept && !err && split_now) ? ST_SPLIT : ST_IDLE;
        req_ready_d  = state_d == ST_IDLE;
        resp_valid_d = in_split || (accept && (err || !split_now));
        resp_err_d   = accept && err;
        addr_d       = accept ? req_addr : addr_q;
        size_d       = accept ? req_size : size_q;
        uns_d        = accept ? req_unsigned : uns_q;
        we_d         = accept ? req_we : we_q;
        wdata_d      = accept ? req_wdata : wdata_q;
        b0_d         = in_split ? dout : b0_q;
        // Beat-1 lanes come fresh from the RAMs; the rest were captured after beat 0.
        m1           = is_split(q_off, q_n) ? beat_mask(q_off, q_n, 1'b1) : '1;
        gath         = (dout & bytes_of(m1)) | (b0_q & ~bytes_of(m1));
        rot          = rotr(gath, q_off);
        msk          = (size_q == SZ_B) ? XLEN'(8'hFF) : (size_q == SZ_H) ? XLEN'(16'hFFFF) : '1;
        sb           = (size_q == SZ_B) ? rot[7] : rot[15];
        ext          = (rot & msk) | ((sb && !uns_q) ? ~msk : '0);
        rdata_now    = (we_q || resp_err_q) ? '0 : ext;
        hold_d       = resp_valid_q ? rdata_now : hold_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            addr_q       <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            b0_q         <= '0;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            b0_q         <= b0_d;
            hold_q       <= hold_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        dmem_lane #(.AW(WW)) u_lane (
            .clk  (clk),
            .re   (lre[i]),
            .we   (lwe[i]),
            .addr (widx),
            .din  (din[8*i +: 8]),
            .dout (dout[8*i +: 8])
        );
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_valid_q ? rdata_now : hold_q;
endmodule

// File: doc/banked_data_memory.md
# banked_data_memory

Parametrised, byte-lane-banked data memory for the pipelined core's MEM stage. Accepts one load or store per cycle via a valid/ready request port. Performs byte/half/word lane steering, sign or zero extension on loads, and splits accesses that straddle a word boundary into two internal beats. Returns a registered response, so the core needs no external byte-select or extension logic.

## Interface
- `ADDR_WIDTH`, 14: byte-address width.
- `LANES`, 4: byte lanes per word; a power of two, ≥2. Word width `XLEN = 8*LANES`.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted this cycle when high together with `req_valid`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in ADDR_WIDTH: byte address.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `req_unsigned` in 1: loads zero-extend when 1, sign-extend when 0.
- `req_wdata` in XLEN: store data, right-aligned.
- `resp_valid` out 1: one-cycle pulse per accepted request.
- `resp_rdata` out XLEN: extended load data; 0 for stores and errors.
- `resp_err` out 1: reserved size; no memory access is made.

## Operation
- Storage: `LANES` independent lane RAMs.
  - Each is 8 bits wide with depth 2^(ADDR_WIDTH−log2 LANES).
  - Word index = `req_addr[ADDR_WIDTH-1:log2 LANES]`.
  - Lane offset = low bits.
  - Contents are not reset.
- Access bytes: 1/2/LANES for size 00/01/10. Bytes occupy lanes offset…offset+n−1, modulo LANES.
- Unaligned accesses are legal. If offset+n ≤ LANES the access is single-beat. Otherwise it splits:
  - Beat 0 hits word W at lanes offset…LANES−1.
  - Beat 1 hits word W+1 at lanes 0…(offset+n−LANES−1).
  - W+1 wraps to word 0 at the top of memory.
- Store: `req_wdata` is rotated left by offset bytes and written under the per-lane enables of each beat. Lanes outside the access are untouched.
- Load: lane bytes are gathered, rotated right by offset, masked to n bytes, then extended from bit 8n−1 per `req_unsigned`.
- FSM states:
  - IDLE: `req_ready`=1. On accept: if single-beat or error, stay in IDLE; if split, go to SPLIT and latch addr, size, unsigned, we, wdata and the beat-0 read bytes.
  - SPLIT: `req_ready`=0. Perform beat 1, then return to IDLE.
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, all latches 0.
- Reset during SPLIT:
  - Beat 1 is abandoned and no response is produced.
  - A beat-0 store write is already committed; this partial write is accepted behaviour.
- Reserved size: no lane enables are asserted. The response carries `resp_err`=1 and `resp_rdata`=0.

## Timing
- Single-beat request accepted at cycle N: lane RAM access at edge N+1; `resp_valid` and data visible in cycle N+1.
- Split request accepted at cycle N: beat 0 at edge N+1, beat 1 at edge N+2; response in cycle N+2. `req_ready` is low during cycle N+1.
- Throughput: 1 request/cycle for single-beat; 2 cycles for split.
- Store followed by a load to the same address next cycle returns the new data (write completes at an earlier edge; no bypass needed).
- No response back-pressure: the consumer must take `resp_*` in the pulse cycle.
- `resp_rdata` holds its value between pulses; `resp_valid` and `resp_err` are single-cycle.

## Structure
- Shared package `dmem_pkg`: size encodings (`SZ_B`, `SZ_H`, `SZ_W`, `SZ_RSV`), FSM state encoding, and the `LANE_BITS = $clog2(LANES)` helper.
- Sub-module `dmem_lane`: one 8-bit synchronous single-port RAM with we/re and registered DOUT, instantiated `LANES` times in a generate loop.
- Steering, extension and the FSM live in the top level.

## Test plan
- Word store 0xDEADBEEF @0x10, then word load @0x10 → response at N+1 = 0xDEADBEEF, `resp_err`=0.
- Byte store 0x80 @0x13:
  - signed byte load @0x13 → 0xFFFFFF80;
  - unsigned byte load → 0x00000080;
  - word load @0x10 → 0x80ADBEEF.
- Half store 0xA55A @0x23 (split):
  - `req_ready` low one cycle, lanes 3 of word 8 and 0 of word 9 written;
  - unsigned half load @0x23 → 0x0000A55A after 2 cycles.
- Word load @ top address 0x3FFE (ADDR_WIDTH=14) → bytes 0x3FFE, 0x3FFF, 0x0000, 0x0001 combined; word 0 is read via wrap.
- Back-to-back aligned loads @0x0, 0x4, 0x8 on consecutive cycles → three consecutive `resp_valid` pulses, in order, `req_ready` always 1.
- `req_size`=11 store → `resp_err`=1, memory unchanged. Split store with `rst` asserted in SPLIT → no response, only beat-0 bytes changed, outputs at reset values.
